// File: rtl/mod_inverse_unit.sv
// Modular inverse a^-1 mod m by iterative extended Euclid on a restoring divider,
// with an optional upward search for the first odd exponent coprime to m.
module mod_inverse_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             auto_e,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] m,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [WIDTH-1:0] e_out,
    output logic [WIDTH-1:0] inv
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_DIV, S_UPDATE, S_CHECK, S_NEXT, S_FIX, S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0]        m_q, cand_q, r0_q, r1_q, p_q, qd_q, emod_q;
    logic signed [WIDTH:0]   s0_q, s1_q;
    logic [CW-1:0]           cnt_q;
    logic                    auto_q, busy_q, done_q, err_q;
    logic [WIDTH-1:0]        eout_q, inv_q;

    logic                    load_err, div_last, rem_zero, gcd_one, next_oob;
    logic                    sub_ok, accept_c, fail_c;
    logic [WIDTH:0]          rem_sh, diff, cand_sum, prod_lo;
    logic [WIDTH-1:0]        p_nx, inv_fix;
    logic signed [WIDTH:0]   s_nx;

    assign load_err = (m_q < WIDTH'(2)) || (cand_q == '0) || (auto_q && cand_q >= m_q);
    assign div_last = (cnt_q == CW'(WIDTH-1));
    assign rem_zero = (p_q == '0);
    assign gcd_one  = (r1_q == WIDTH'(1));
    assign cand_sum = {1'b0, cand_q} + (WIDTH+1)'(2);
    assign next_oob = (cand_sum >= {1'b0, m_q});

    // One restoring step: the difference can go negative only by less than 2^WIDTH,
    // so its top bit doubles as the borrow.
    assign rem_sh = {p_q, qd_q[WIDTH-1]};
    assign diff   = rem_sh - {1'b0, r1_q};
    assign sub_ok = ~diff[WIDTH];
    assign p_nx   = sub_ok ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];

    // Only the low WIDTH+1 bits of q*s1 are kept; |s| <= m keeps the result exact.
    assign prod_lo = {1'b0, qd_q} * $unsigned(s1_q);
    assign s_nx    = s0_q - $signed(prod_lo);
    assign inv_fix = s1_q[WIDTH] ? (s1_q[WIDTH-1:0] + m_q) : s1_q[WIDTH-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_LOAD;
            S_LOAD:   state_d = load_err ? S_DONE : S_DIV;
            S_DIV:    if (div_last) state_d = S_UPDATE;
            S_UPDATE: state_d = rem_zero ? S_CHECK : S_DIV;
            S_CHECK:  state_d = gcd_one ? S_FIX : (auto_q ? S_NEXT : S_DONE);
            S_NEXT:   state_d = next_oob ? S_DONE : S_LOAD;
            S_FIX:    state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        accept_c = 1'b0;
        fail_c   = 1'b0;
        case (state_q)
            S_IDLE:  accept_c = start;
            S_LOAD:  fail_c   = load_err;
            S_CHECK: fail_c   = !gcd_one && !auto_q;
            S_NEXT:  fail_c   = next_oob;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_q <= '0; cand_q <= '0; r0_q <= '0; r1_q <= '0;
            p_q <= '0; qd_q <= '0; emod_q <= '0; cnt_q <= '0;
            s0_q <= '0; s1_q <= '0; auto_q <= 1'b0;
            busy_q <= 1'b0; done_q <= 1'b0; err_q <= 1'b0;
            eout_q <= '0; inv_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (accept_c) begin
                m_q    <= m;
                cand_q <= auto_e ? (a | WIDTH'(1)) : a;
                auto_q <= auto_e;
                busy_q <= 1'b1;
                err_q  <= 1'b0;
            end
            case (state_q)
                S_LOAD: begin
                    r0_q   <= m_q;
                    r1_q   <= cand_q;
                    s0_q   <= '0;
                    s1_q   <= (WIDTH+1)'(1);
                    p_q    <= '0;
                    qd_q   <= m_q;
                    cnt_q  <= '0;
                    emod_q <= cand_q;
                end
                S_DIV: begin
                    p_q   <= p_nx;
                    qd_q  <= {qd_q[WIDTH-2:0], sub_ok};
                    cnt_q <= cnt_q + CW'(1);
                end
                S_UPDATE: begin
                    // Dividing by m only happens after the a>=m swap; that remainder is a mod m.
                    if (r1_q == m_q) emod_q <= p_q;
                    if (!rem_zero) begin
                        r0_q  <= r1_q;
                        r1_q  <= p_q;
                        s0_q  <= s1_q;
                        s1_q  <= s_nx;
                        p_q   <= '0;
                        qd_q  <= r1_q;
                        cnt_q <= '0;
                    end
                end
                S_NEXT: if (!next_oob) cand_q <= cand_sum[WIDTH-1:0];
                S_FIX: begin
                    inv_q  <= inv_fix;
                    eout_q <= emod_q;
                end
                S_DONE: begin
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                end
                default: ;
            endcase
            if (fail_c) begin
                err_q  <= 1'b1;
                inv_q  <= '0;
                eout_q <= '0;
            end
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign error = err_q;
    assign e_out = eout_q;
    assign inv   = inv_q;
endmodule

// File: tb/tb_mod_inverse_unit.sv
// Scoreboard bench for mod_inverse_unit: a 32-bit and an 8-bit instance share one clock.
module tb_mod_inverse_unit;
    localparam int BOUND = 5000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        st32, ae32, busy32, done32, error32;
    logic [31:0] a32, m32, e32, inv32;
    logic        st8, ae8, busy8, done8, error8;
    logic [7:0]  a8, m8, e8, inv8;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic        err;
        logic [31:0] e;
        logic [31:0] iv;
        bit          ce;
    } exp_t;

    exp_t q32[$];
    exp_t q8[$];

    always #5 clk = ~clk;

    mod_inverse_unit #(.WIDTH(32)) u_d32 (
        .clk(clk), .reset(rst_n), .start(st32), .auto_e(ae32), .a(a32), .m(m32),
        .busy(busy32), .done(done32), .error(error32), .e_out(e32), .inv(inv32)
    );

    mod_inverse_unit #(.WIDTH(8)) u_d8 (
        .clk(clk), .reset(rst_n), .start(st8), .auto_e(ae8), .a(a8), .m(m8),
        .busy(busy8), .done(done8), .error(error8), .e_out(e8), .inv(inv8)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin : mon32
        exp_t x;
        if (done32) begin
            if (q32.size() == 0) chk("spurious_done32", 1, 0);
            else begin
                x = q32.pop_front();
                chk("err32", error32, x.err);
                chk("inv32", inv32, x.iv);
                if (x.ce) chk("e32", e32, x.e);
            end
        end
    end

    always @(negedge clk) begin : mon8
        exp_t x;
        if (done8) begin
            if (q8.size() == 0) chk("spurious_done8", 1, 0);
            else begin
                x = q8.pop_front();
                chk("err8", error8, x.err);
                chk("inv8", {24'd0, inv8}, x.iv);
                if (x.ce) chk("e8", {24'd0, e8}, x.e);
            end
        end
    end

    task automatic apply(input bit w8, input bit ae, input logic [31:0] av, input logic [31:0] mv,
                         input bit xerr, input logic [31:0] xe, input logic [31:0] xinv,
                         output int lat);
        exp_t x;
        logic dn;
        x.err = xerr; x.e = xe; x.iv = xinv; x.ce = !xerr;
        if (w8) begin
            q8.push_back(x); a8 = av[7:0]; m8 = mv[7:0]; ae8 = ae; st8 = 1'b1;
        end else begin
            q32.push_back(x); a32 = av; m32 = mv; ae32 = ae; st32 = 1'b1;
        end
        @(negedge clk);
        st8 = 1'b0; st32 = 1'b0;
        // inputs are free to change once the start cycle is over
        a32 = $urandom; m32 = $urandom; ae32 = 1'($urandom);
        a8 = 8'($urandom); m8 = 8'($urandom); ae8 = 1'($urandom);
        lat = 1;
        chk("busy_rise", w8 ? busy8 : busy32, 1);
        dn = w8 ? done8 : done32;
        while (!dn && lat < BOUND) begin
            @(negedge clk);
            lat++;
            dn = w8 ? done8 : done32;
        end
        if (!dn) chk("timeout", 0, 1);
        else     chk("busy_fall", w8 ? busy8 : busy32, 0);
        @(negedge clk);
        chk("done_pulse", w8 ? done8 : done32, 0);
    endtask

    initial begin
        int lat;
        logic dn;
        rst_n = 1'b0;
        st32 = 1'b0; ae32 = 1'b0; a32 = '0; m32 = '0;
        st8 = 1'b0; ae8 = 1'b0; a8 = '0; m8 = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy32, 0);
        chk("rst_done", done32, 0);
        chk("rst_err", error32, 0);
        chk("rst_e", e32, 0);
        chk("rst_inv", inv32, 0);
        chk("rst_busy8", busy8, 0);
        chk("rst_inv8", inv8, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // direct mode
        apply(0, 0, 3, 20, 0, 3, 7, lat);
        apply(0, 0, 23, 20, 0, 3, 7, lat);
        apply(0, 0, 1, 2, 0, 1, 1, lat);
        apply(0, 0, 2, 1000000007, 0, 2, 500000004, lat);
        apply(0, 0, 3, 1000000007, 0, 3, 333333336, lat);
        // key flow
        apply(0, 1, 3, 88, 0, 3, 59, lat);
        apply(0, 1, 11, 88, 0, 13, 61, lat);
        // errors
        apply(0, 0, 4, 20, 1, 0, 0, lat);
        apply(0, 0, 40, 20, 1, 0, 0, lat);
        apply(0, 0, 5, 1, 1, 0, 0, lat);
        chk("lat_m_lt_2", lat, 3);
        apply(0, 0, 0, 20, 1, 0, 0, lat);
        chk("lat_cand0", lat, 3);
        apply(0, 1, 10, 10, 1, 0, 0, lat);
        chk("lat_cand_ge_m", lat, 3);
        // search corners
        apply(0, 1, 9, 10, 0, 9, 9, lat);
        apply(0, 1, 8, 10, 0, 9, 9, lat);
        apply(0, 1, 11, 12, 0, 11, 11, lat);
        apply(0, 1, 10, 12, 0, 11, 11, lat);
        // narrow width
        apply(1, 0, 255, 254, 0, 1, 1, lat);
        apply(1, 0, 2, 255, 0, 2, 128, lat);
        apply(1, 1, 3, 254, 0, 3, 85, lat);

        // start while busy is ignored
        begin
            exp_t x;
            x.err = 1'b0; x.e = 3; x.iv = 333333336; x.ce = 1'b1;
            q32.push_back(x);
            a32 = 3; m32 = 1000000007; ae32 = 1'b0; st32 = 1'b1;
            @(negedge clk);
            st32 = 1'b0;
            repeat (20) @(negedge clk);
            a32 = 4; m32 = 20; st32 = 1'b1;
            @(negedge clk);
            st32 = 1'b0;
            lat = 0;
            dn = done32;
            while (!dn && lat < BOUND) begin
                @(negedge clk);
                lat++;
                dn = done32;
            end
            if (!dn) chk("timeout_busy_start", 0, 1);
            repeat (60) @(negedge clk);
            chk("busy_start_idle", busy32, 0);
        end

        // reset in the middle of a divide
        a32 = 2; m32 = 1000000007; ae32 = 1'b0; st32 = 1'b1;
        @(negedge clk);
        st32 = 1'b0;
        repeat (10) @(negedge clk);
        chk("pre_rst_busy", busy32, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy32, 0);
        chk("mid_rst_done", done32, 0);
        chk("mid_rst_err", error32, 0);
        chk("mid_rst_e", e32, 0);
        chk("mid_rst_inv", inv32, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        chk("post_rst_busy", busy32, 0);
        apply(0, 0, 3, 20, 0, 3, 7, lat);

        chk("queue32_drained", q32.size(), 0);
        chk("queue8_drained", q8.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mod_inverse_unit.md
# mod_inverse_unit

Parametrised modular-inverse engine for the RSA key-generation path: given a modulus m (normally φ(n)) and a value a, computes a⁻¹ mod m by iterative extended Euclid with a shift-subtract divider. In auto-exponent mode it also searches upward from a starting candidate for the first odd e coprime to m, then returns both e and d = e⁻¹ mod m. It replaces the fixed 32-bit key inverter with a start/done handshake, coprimality error reporting and a selectable width.

## Interface

- WIDTH, 32, operand width in bits; must be ≥ 4.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- auto_e  input  1  sampled with start. 0 selects direct inverse of a; 1 selects exponent search from a.
- a  input  WIDTH  value to invert, or the starting candidate when auto_e=1; sampled with start.
- m  input  WIDTH  modulus; sampled with start.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse when results are valid.
- error  output  1  valid with done; held until the next accepted start.
- e_out  output  WIDTH  selected exponent; equals a mod m in direct mode.
- inv  output  WIDTH  inverse in [1, m-1]; 0 when error=1.

## Operation

- States: IDLE, LOAD, DIV, UPDATE, CHECK, NEXT, FIX, DONE.
- IDLE: start=1 latches a, m and auto_e and goes to LOAD. In auto mode, bit 0 of the candidate is forced to 1.
- LOAD: registers r0=m, r1=cand, s0=0, s1=1. Immediate error goes to DONE with error=1 when:
  - m < 2;
  - cand = 0;
  - auto mode and cand ≥ m.
- DIV: restoring shift-subtract of r0 by r1. Takes exactly WIDTH cycles and produces q and rem.
- UPDATE: (r0,r1) ← (r1,rem); (s0,s1) ← (s1, s0 − q·s1).
  - s registers are signed, WIDTH+1 bits.
  - q·s1 is computed as a full product, then truncated to WIDTH+1 bits. The Euclid bound |s| ≤ m guarantees there is no loss.
- After UPDATE, rem≠0 returns to DIV; rem=0 goes to CHECK.
- CHECK: r1 now holds gcd(m, cand).
  - gcd=1: go to FIX.
  - gcd≠1, direct mode: DONE with error=1.
  - gcd≠1, auto mode: go to NEXT.
- NEXT: cand ← cand+2.
  - If cand+2 ≥ m (compare with a WIDTH+1-bit sum, so there is no wrap), DONE with error=1.
  - Otherwise go to LOAD.
- FIX: inv ← s1 + m when s1 < 0, else s1; e_out ← cand. The value is always in [1, m−1].
- DONE: pulse done, clear busy, return to IDLE.
- Direct mode with a ≥ m is legal. The first DIV yields q=0, which swaps the operands. e_out reports a mod m.
- start while busy is ignored and does not queue.
- The input buses may change freely after the start cycle.

## Timing

- Reset (reset=0, asynchronous) clears state to IDLE and clears busy, done, error, e_out and inv to 0.
- Reset mid-operation aborts the computation immediately. No done pulse is issued.
- busy rises the cycle after start and falls in the same cycle done pulses.
- Outputs are registered and hold their values from done until the next accepted start.
- Latency per candidate = 1 (LOAD) + k·(WIDTH+1) + 1 (CHECK), where k is the number of Euclid steps (k ≤ 1.5·WIDTH+2). Add 1 for FIX and 1 for DONE on success.
- Auto mode adds 1 NEXT cycle per rejected candidate.
- Immediate-error latency is 3 cycles from start to done.
- done is never asserted in the same cycle as start.

## Test plan

- Direct mode, WIDTH=32: a=3, m=20, auto_e=0 -> done with error=0, inv=7, e_out=3; busy low after done.
- Key flow, auto mode: p=23, q=5, so m=88, with a=3 -> e_out=3, inv=59, error=0. Repeat with a=11 -> 11 is rejected (gcd=11), e_out=13, inv=61.
- Non-coprime direct: a=4, m=20 -> error=1, inv=0. Also m=1 -> error=1 three cycles after start.
- Exhausted search: a=9, m=10, auto_e=1 -> 9 is coprime, so e_out=9, inv=9. Then a=8, m=10 -> candidate 9, e_out=9. Then m=12, a=11 -> inv=11; a=10 is forced to 11 -> inv=11.
- Overflow corner, WIDTH=8: a=255, m=254, direct -> e_out=1, inv=1. Also a=2, m=255 -> inv=128 (2·128 = 256 ≡ 1).
- Control: assert start while busy -> ignored and the result is unchanged. Assert reset=0 mid-DIV -> all outputs 0 immediately and no done pulse; a fresh start then completes normally.
